irq_req_capture: RTL and testbench

- Request-capture stage that sits directly upstream of the 4-to-2 priority encoder.
- Turns raw level request lines into sticky, maskable pending bits. The masked pending vector drives the encoder input.
- Pending bits are cleared only when the consumer acknowledges the index returned by the encoder.
- Also flags lost requests: per-channel overrun bits and a saturating miss counter.

---
 rtl/irq_req_capture.sv | 79 +++++++
 tb/tb_irq_req_capture.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_req_capture.sv
// Request capture ahead of the 4-to-2 priority encoder: edge-detected, sticky,
// maskable pending bits cleared by acknowledge, with overrun flags and a miss counter.
module irq_req_capture #(
   parameter int N  = 4,
   parameter int IW = 2,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic          ack,
   input  logic [IW-1:0] ack_idx,
   output logic [N-1:0]  pend,
   output logic          irq,
   output logic [N-1:0]  ovr,
   output logic [CW-1:0] miss_cnt
);

   localparam logic [CW-1:0] MISS_MAX = '1;

   logic [N-1:0]  req_q;
   logic [N-1:0]  pending;
   logic [N-1:0]  rise;
   logic [N-1:0]  ack_vec;
   logic [N-1:0]  overrun;
   logic [N-1:0]  pending_nxt;
   logic [N-1:0]  ovr_nxt;
   logic [CW:0]   ovr_count;
   logic [CW:0]   miss_sum;
   logic [CW-1:0] miss_nxt;

   // A rise always wins over a same-cycle ack of that channel, so a fresh request
   // is never lost and is not counted as an overrun.
   always_comb begin
      rise        = req & ~req_q;
      ack_vec     = '0;
      overrun     = '0;
      pending_nxt = pending;
      ovr_nxt     = ovr;
      ovr_count   = '0;
      for (int k = 0; k < N; k++) begin
         ack_vec[k] = ack && (ack_idx == IW'(k));
         overrun[k] = rise[k] && pending[k] && !ack_vec[k];
         if (rise[k]) begin
            pending_nxt[k] = 1'b1;
         end else if (ack_vec[k]) begin
            pending_nxt[k] = 1'b0;
         end
         if (overrun[k]) begin
            ovr_nxt[k] = 1'b1;
         end else if (ack_vec[k] && !rise[k]) begin
            ovr_nxt[k] = 1'b0;
         end
         ovr_count = ovr_count + {{CW{1'b0}}, overrun[k]};
      end
      miss_sum = {1'b0, miss_cnt} + ovr_count;
      miss_nxt = (miss_sum > {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[CW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q    <= '0;
         pending  <= '0;
         ovr      <= '0;
         miss_cnt <= '0;
      end else begin
         req_q    <= req;
         pending  <= pending_nxt;
         ovr      <= ovr_nxt;
         miss_cnt <= miss_nxt;
      end
   end

   // Mask gates only the presentation to the encoder; capture continues underneath.
   assign pend = pending & ~mask;
   assign irq  = |pend;

endmodule

// File: tb/tb_irq_req_capture.sv
// Scoreboard bench for irq_req_capture: each scenario pushes expected outputs
// as it drives stimulus and pops/compares them once the DUT has responded.
module tb_irq_req_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       ack;
   logic [1:0] ack_idx;
   logic [3:0] pend;
   logic       irq;
   logic [3:0] ovr;
   logic [7:0] miss_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [16:0] val;
   } exp_t;

   typedef struct packed {
      logic [3:0] req_v;
      logic [3:0] mask_v;
      logic       ack_v;
      logic [1:0] idx_v;
      logic [3:0] pend_e;
      logic       irq_e;
      logic [3:0] ovr_e;
      logic [7:0] miss_e;
      logic       nc;
   } row_t;

   exp_t sb[$];

   irq_req_capture #(.N(4), .IW(2), .CW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .mask     (mask),
      .ack      (ack),
      .ack_idx  (ack_idx),
      .pend     (pend),
      .irq      (irq),
      .ovr      (ovr),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic row_t mk(input logic [3:0] r, input logic [3:0] m, input logic a,
                               input logic [1:0] i, input logic [3:0] p, input logic q,
                               input logic [3:0] o, input logic [7:0] ms, input logic nc = 1'b0);
      row_t x;
      x.req_v = r; x.mask_v = m; x.ack_v = a; x.idx_v = i;
      x.pend_e = p; x.irq_e = q; x.ovr_e = o; x.miss_e = ms; x.nc = nc;
      return x;
   endfunction

   task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic a, input logic [1:0] i);
      @(negedge clk);
      req = r; mask = m; ack = a; ack_idx = i;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd0, 1'b1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 8'd0));
      repeat (3) @(posedge clk);
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("reset_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         if (rows[i].nc) #1; else tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
         if (i == 0) rst_n = 1'b1;
      end
   endtask

   task automatic test_ack();
      row_t rows[$];
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 8'd0));
      rows.push_back(mk(4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1001, 1'b1, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0001, 1'b1, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 8'd0));
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("ack_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   task automatic test_overrun();
      row_t rows[$];
      rows.push_back(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000, 8'd0));
      rows.push_back(mk(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'd1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 8'd1));
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("overrun_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   task automatic test_set_wins();
      row_t rows[$];
      rows.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b0100, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 8'd1));
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("set_wins_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      rows.push_back(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'd1));
      rows.push_back(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b1111, 8'd5));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0111, 1'b1, 4'b0111, 8'd5));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0011, 1'b1, 4'b0011, 8'd5));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0001, 1'b1, 4'b0001, 8'd5));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd5));
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("back_to_back_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   task automatic test_mask();
      row_t rows[$];
      rows.push_back(mk(4'b0011, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd5));
      rows.push_back(mk(4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 8'd5));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0011, 1'b1, 4'b0000, 8'd5, 1'b1));
      rows.push_back(mk(4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000, 8'd5, 1'b1));
      rows.push_back(mk(4'b0011, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0011, 8'd7));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'd7));
      rows.push_back(mk(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 8'd7));
      foreach (rows[i]) begin
         exp_t x;
         exp_t e;
         drive(rows[i].req_v, rows[i].mask_v, rows[i].ack_v, rows[i].idx_v);
         x.name = $sformatf("mask_%0d", i);
         x.val  = {rows[i].pend_e, rows[i].irq_e, rows[i].ovr_e, rows[i].miss_e};
         sb.push_back(x);
         if (rows[i].nc) #1; else tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   // Channel 0 stays pending while req[0] is pulsed 300 times; the counter starts at 7.
   task automatic test_saturation();
      drive(4'b0001, 4'b0000, 1'b0, 2'd0);
      tick();
      for (int n = 0; n <= 300; n++) begin
         exp_t x;
         exp_t e;
         int   m;
         if (n == 300) begin
            drive(4'b0000, 4'b0000, 1'b1, 2'd0);
            x.val = {4'b0000, 1'b0, 4'b0000, 8'd255};
         end else begin
            drive(4'b0000, 4'b0000, 1'b0, 2'd0);
            tick();
            drive(4'b0001, 4'b0000, 1'b0, 2'd0);
            m = 7 + n + 1;
            if (m > 255) m = 255;
            x.val = {4'b0001, 1'b1, 4'b0001, 8'(m)};
         end
         x.name = $sformatf("saturation_%0d", n);
         sb.push_back(x);
         tick();
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
   endtask

   task automatic test_reset_release();
      for (int ph = 0; ph < 5; ph++) begin
         exp_t x;
         exp_t e;
         x.name = $sformatf("reset_release_%0d", ph);
         x.val  = '0;
         case (ph)
            0: begin
               @(negedge clk);
               req = 4'b1010; mask = 4'b0000; ack = 1'b0; ack_idx = 2'd0;
               rst_n = 1'b0;
               sb.push_back(x);
               #1;
            end
            1: begin
               repeat (2) @(posedge clk);
               @(negedge clk);
               rst_n = 1'b1;
               x.val = {4'b1010, 1'b1, 4'b0000, 8'd0};
               sb.push_back(x);
               tick();
            end
            2: begin
               drive(4'b1010, 4'b0000, 1'b1, 2'd3);
               x.val = {4'b0010, 1'b1, 4'b0000, 8'd0};
               sb.push_back(x);
               tick();
            end
            3: begin
               drive(4'b1010, 4'b0000, 1'b0, 2'd0);
               x.val = {4'b0010, 1'b1, 4'b0000, 8'd0};
               sb.push_back(x);
               tick();
            end
            default: begin
               @(posedge clk);
               #2;
               rst_n = 1'b0;
               sb.push_back(x);
               #1;
            end
         endcase
         e = sb.pop_front();
         checks++;
         if ({pend, irq, ovr, miss_cnt} !== e.val) begin
            failures++;
            $display("[TB] FAIL %s got pend=%b irq=%b ovr=%b miss=%0d exp pend=%b irq=%b ovr=%b miss=%0d",
                     e.name, pend, irq, ovr, miss_cnt, e.val[16:13], e.val[12], e.val[11:8], e.val[7:0]);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = 4'b0000;
      mask    = 4'b0000;
      ack     = 1'b0;
      ack_idx = 2'd0;
      test_reset();
      test_ack();
      test_overrun();
      test_set_wins();
      test_back_to_back();
      test_mask();
      test_saturation();
      test_reset_release();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
